lock_status_display: RTL and testbench
======================================

# lock_status_display

Downstream stage of the 4-digit password lock FSM. Consumes its match/mismatch status levels and revealed password value, and:
- counts consecutive wrong guesses;
- enforces a timed lockout after too many failures, and tells the upstream FSM to stop accepting guesses;
- drives a multiplexed 4-digit active-low seven-segment display for the board.

## Interface
Parameters:
- MAX_FAILS, 3, consecutive mismatches that trigger lockout (≥1)
- LOCK_CYCLES, 1000, lockout duration in clk cycles (≥2)
- SCAN_DIV, 4, clk cycles each display digit is held (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- ok_in  in  1  upstream "right password" level (sticky once set)
- err_in  in  1  upstream "wrong password" level (high ≥1 cycle per wrong attempt)
- value_in  in  16  password to display when unlocked; nibble 3 = bits [15:12]
- unlocked  out  1  high in UNLOCKED
- locked_out  out  1  high in LOCKOUT
- guess_block  out  1  high in LOCKOUT and UNLOCKED; upstream gates guess entry with it
- fail_cnt  out  clog2(MAX_FAILS+1)  current consecutive-failure count
- an_n  out  4  digit enables, active-low one-hot; bit i = digit i
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- Edge detect: ok_q/err_q register ok_in/err_in. ok_rise = ok_in & ~ok_q; err_rise = err_in & ~err_q. A held level counts once.
- FSM states: IDLE, UNLOCKED, LOCKOUT.
- IDLE:
  - ok_rise → UNLOCKED, fail_cnt←0.
  - err_rise with fail_cnt = MAX_FAILS-1 → LOCKOUT, timer←LOCK_CYCLES-1, fail_cnt←0.
  - Other err_rise → fail_cnt+1.
  - ok_rise and err_rise in the same cycle: ok wins.
- LOCKOUT: timer decrements each cycle; at timer = 0 → IDLE. ok_rise and err_rise are ignored; edge registers still track inputs.
- UNLOCKED: terminal until rst. All input edges are ignored.
- Display content per state:
  - IDLE: digit 0 shows fail_cnt as hex; digits 1-3 blank.
  - LOCKOUT: all digits show "-" (7'b0111111).
  - UNLOCKED: digit i shows value_in[4i+3:4i] as hex, sampled live.
- Glyph values:
  - hex 0-F: standard, e.g. 0 = 7'b1000000, 3 = 7'b0110000, A = 7'b0001000, F = 7'b0001110.
  - blank = 7'b1111111.
- Scan: divider counts 0..SCAN_DIV-1. On wrap, digit index advances 0→1→2→3→0.

## Timing
- Reset values:
  - state IDLE; fail_cnt 0; timer 0; ok_q 0, err_q 0.
  - unlocked 0, locked_out 0, guess_block 0.
  - digit index 0, divider 0.
  - an_n 4'b1111, seg_n 7'b1111111.
- All outputs registered.
- Input level rising at edge N (visible from N) → state/fail_cnt/status outputs change at edge N+1.
- LOCKOUT lasts exactly LOCK_CYCLES cycles: locked_out high for LOCK_CYCLES clocks, then IDLE.
- an_n/seg_n are registered from the current digit index and current state, so display content lags state by one cycle.
- First display update is at the first clk edge after rst release: an_n=1110, showing digit 0.
- Mid-operation rst clears everything asynchronously, including an in-progress lockout.

## Structure
- Package lock_status_pkg:
  - state enum (IDLE=2'd0, UNLOCKED=2'd1, LOCKOUT=2'd2);
  - glyph constants GLYPH_BLANK and GLYPH_DASH.
- Sub-module seg7_decoder: purely combinational 4-bit hex → 7-bit active-low segments. Instantiated once, fed by the digit mux.
- Top level holds edge detect, FSM, failure counter, lockout timer, scan divider and digit mux.

## Test plan
Bench parameters: MAX_FAILS=3, LOCK_CYCLES=8, SCAN_DIV=2.
- Reset: assert rst mid-scan → all outputs at reset values immediately. Release → an_n=1110, seg_n=7'b1000000 after one edge.
- Held error: err_in pulsed high 3 cycles once → fail_cnt=1, not 3. Digit 0 shows "1" (7'b1111001).
- Lockout: three separated err_in pulses →
  - locked_out=1 and guess_block=1 for exactly 8 cycles;
  - all digits "-" during lockout;
  - then IDLE with fail_cnt=0;
  - an err_in pulse during lockout has no effect.
- Unlock: one err_in pulse, then ok_in=1 with value_in=16'h3A0F →
  - unlocked=1, fail_cnt=0;
  - digit scan shows F,0,A,3 on digits 0..3;
  - later err_in pulses have no effect.
- Tie: ok_in and err_in rise in the same cycle with fail_cnt=2 → UNLOCKED, not LOCKOUT.
- Scan: in UNLOCKED, an_n sequence is 1110,1110,1101,1101,1011,1011,0111,0111, then repeats.

Source files
------------

// File: rtl/lock_status_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lock_status_pkg : state encoding and fixed glyphs for lock_status_display
// Rev 1.0
// ---------------------------------------------------------------------------
package lock_status_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_decoder : 4-bit hex to active-low {g,f,e,d,c,b,a} segments
// Rev 1.0
// ---------------------------------------------------------------------------
module seg7_decoder (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = 7'b0001110;
    case (i_hex)
      4'h0: o_seg_n = 7'b1000000;
      4'h1: o_seg_n = 7'b1111001;
      4'h2: o_seg_n = 7'b0100100;
      4'h3: o_seg_n = 7'b0110000;
      4'h4: o_seg_n = 7'b0011001;
      4'h5: o_seg_n = 7'b0010010;
      4'h6: o_seg_n = 7'b0000010;
      4'h7: o_seg_n = 7'b1111000;
      4'h8: o_seg_n = 7'b0000000;
      4'h9: o_seg_n = 7'b0010000;
      4'hA: o_seg_n = 7'b0001000;
      4'hB: o_seg_n = 7'b0000011;
      4'hC: o_seg_n = 7'b1000110;
      4'hD: o_seg_n = 7'b0100001;
      4'hE: o_seg_n = 7'b0000110;
      default: o_seg_n = 7'b0001110;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lock_status_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lock_status_display : failure counting, timed lockout and 4-digit display
// Rev 1.0
// ---------------------------------------------------------------------------
module lock_status_display
  import lock_status_pkg::*;
#(
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1000,
  parameter int SCAN_DIV    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ok_in,
  input  logic                             err_in,
  input  logic [15:0]                      value_in,
  output logic                             unlocked,
  output logic                             locked_out,
  output logic                             guess_block,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
  output logic [3:0]                       an_n,
  output logic [6:0]                       seg_n
);

  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int TW  = $clog2(LOCK_CYCLES);
  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic           r_ok_q;
  logic           r_err_q;
  state_t         r_state;
  logic [TW-1:0]  r_timer;
  logic [DW-1:0]  r_div;
  logic [1:0]     r_digit;

  logic           w_ok_rise;
  logic           w_err_rise;
  state_t         w_state_nxt;
  logic [FCW-1:0] w_fail_nxt;
  logic [TW-1:0]  w_timer_nxt;
  logic           w_show_hex;
  logic [3:0]     w_nib;
  logic [6:0]     w_fixed;
  logic [6:0]     w_dec;

  assign w_ok_rise  = ok_in  & ~r_ok_q;
  assign w_err_rise = err_in & ~r_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ok_q      <= 1'b0;
      r_err_q     <= 1'b0;
      r_state     <= IDLE;
      fail_cnt    <= '0;
      r_timer     <= '0;
      unlocked    <= 1'b0;
      locked_out  <= 1'b0;
      guess_block <= 1'b0;
    end else begin
      r_ok_q      <= ok_in;
      r_err_q     <= err_in;
      r_state     <= w_state_nxt;
      fail_cnt    <= w_fail_nxt;
      r_timer     <= w_timer_nxt;
      unlocked    <= (w_state_nxt == UNLOCKED);
      locked_out  <= (w_state_nxt == LOCKOUT);
      guess_block <= (w_state_nxt != IDLE);
    end
  end

  // ok_in is checked first so a simultaneous ok/err pair unlocks
  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = fail_cnt;
    w_timer_nxt = r_timer;
    case (r_state)
      IDLE: begin
        if (w_ok_rise) begin
          w_state_nxt = UNLOCKED;
          w_fail_nxt  = '0;
        end else if (w_err_rise) begin
          if (fail_cnt == FCW'(MAX_FAILS - 1)) begin
            w_state_nxt = LOCKOUT;
            w_timer_nxt = TW'(LOCK_CYCLES - 1);
            w_fail_nxt  = '0;
          end else begin
            w_fail_nxt = fail_cnt + 1'b1;
          end
        end
      end
      LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      UNLOCKED: w_state_nxt = UNLOCKED;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_show_hex = 1'b0;
    w_nib      = 4'h0;
    w_fixed    = GLYPH_BLANK;
    case (r_state)
      IDLE: begin
        if (r_digit == 2'd0) begin
          w_show_hex = 1'b1;
          w_nib      = 4'(fail_cnt);
        end
      end
      LOCKOUT:  w_fixed = GLYPH_DASH;
      UNLOCKED: begin
        w_show_hex = 1'b1;
        w_nib      = value_in[{r_digit, 2'b00} +: 4];
      end
      default:  w_fixed = GLYPH_BLANK;
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .i_hex   (w_nib),
    .o_seg_n (w_dec)
  );

  // display registers use the pre-advance digit index, so the first
  // edge after reset shows digit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_digit <= 2'd0;
      an_n    <= 4'b1111;
      seg_n   <= GLYPH_BLANK;
    end else begin
      an_n  <= ~(4'b0001 << r_digit);
      seg_n <= w_show_hex ? w_dec : w_fixed;
      if (r_div == DW'(SCAN_DIV - 1)) begin
        r_div   <= '0;
        r_digit <= r_digit + 2'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lock_status_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lock_status_display : scoreboard bench for lock_status_display
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_lock_status_display;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ok_in = 1'b0;
  logic        err_in = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic        unlocked;
  logic        locked_out;
  logic        guess_block;
  logic [1:0]  fail_cnt;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  int n_cmp = 0;
  int n_bad = 0;

  string       q_tag[$];
  logic [31:0] q_val[$];

  lock_status_display #(
    .MAX_FAILS   (3),
    .LOCK_CYCLES (8),
    .SCAN_DIV    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ok_in       (ok_in),
    .err_in      (err_in),
    .value_in    (value_in),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .guess_block (guess_block),
    .fail_cnt    (fail_cnt),
    .an_n        (an_n),
    .seg_n       (seg_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    q_tag.push_back(tag);
    q_val.push_back(v);
  endtask

  task automatic observe(input logic [31:0] got);
    string       tag;
    logic [31:0] v;
    tag = q_tag.pop_front();
    v   = q_val.pop_front();
    chk(tag, got, v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ok_in    = 1'b0;
    err_in   = 1'b0;
    value_in = 16'h0000;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_err(input int n);
    err_in = 1'b1;
    repeat (n) tick();
    err_in = 1'b0;
    tick();
  endtask

  task automatic wait_digit(input int d);
    logic [3:0] want;
    want = ~(4'b0001 << d);
    tick();
    for (int k = 0; k < 20 && an_n !== want; k++) tick();
    if (an_n !== want) chk("scan_timeout", 32'(an_n), 32'(want));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat [4];
    logic [3:0] prev;
    int         n;
    bit         found;
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

    // power-up reset and first display update
    repeat (2) tick();
    rst = 1'b0;
    push_exp("first_an", 32'(4'b1110));
    push_exp("first_seg", 32'(SEG_0));
    push_exp("first_unlocked", 0);
    push_exp("first_guess_block", 0);
    tick();
    observe(32'(an_n));
    observe(32'(seg_n));
    observe(32'(unlocked));
    observe(32'(guess_block));

    // held error level counts once
    push_exp("held_err_fail_cnt", 1);
    pulse_err(3);
    observe(32'(fail_cnt));
    push_exp("held_err_digit0", 32'(SEG_1));
    wait_digit(0);
    observe(32'(seg_n));
    push_exp("idle_digit1_blank", 32'(SEG_BLANK));
    wait_digit(1);
    observe(32'(seg_n));

    // asynchronous reset mid-scan
    tick();
    push_exp("async_rst_an", 32'(4'b1111));
    push_exp("async_rst_seg", 32'(SEG_BLANK));
    push_exp("async_rst_fail_cnt", 0);
    push_exp("async_rst_locked_out", 0);
    rst = 1'b1;
    #1;
    observe(32'(an_n));
    observe(32'(seg_n));
    observe(32'(fail_cnt));
    observe(32'(locked_out));
    tick();
    rst = 1'b0;
    push_exp("rst_release_an", 32'(4'b1110));
    push_exp("rst_release_seg", 32'(SEG_0));
    tick();
    observe(32'(an_n));
    observe(32'(seg_n));

    // lockout after three separated failures
    pulse_err(1);
    pulse_err(1);
    push_exp("lockout_enter_locked_out", 1);
    push_exp("lockout_enter_guess_block", 1);
    push_exp("lockout_enter_fail_cnt", 0);
    err_in = 1'b1;
    tick();
    err_in = 1'b0;
    observe(32'(locked_out));
    observe(32'(guess_block));
    observe(32'(fail_cnt));
    n = 1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (!locked_out) break;
      n++;
      chk("lockout_dash", 32'(seg_n), 32'(SEG_DASH));
      if (k == 1) err_in = 1'b1;
      if (k == 2) err_in = 1'b0;
    end
    push_exp("lockout_length", 8);
    observe(32'(n));
    push_exp("lockout_exit_guess_block", 0);
    push_exp("lockout_exit_fail_cnt", 0);
    observe(32'(guess_block));
    observe(32'(fail_cnt));
    push_exp("lockout_exit_digit0", 32'(SEG_0));
    wait_digit(0);
    observe(32'(seg_n));
    push_exp("after_lockout_fail_cnt", 1);
    pulse_err(1);
    observe(32'(fail_cnt));

    // unlock and live value display
    do_reset();
    pulse_err(1);
    value_in = 16'h3A0F;
    ok_in    = 1'b1;
    push_exp("unlock_unlocked", 1);
    push_exp("unlock_fail_cnt", 0);
    push_exp("unlock_guess_block", 1);
    push_exp("unlock_locked_out", 0);
    tick();
    observe(32'(unlocked));
    observe(32'(fail_cnt));
    observe(32'(guess_block));
    observe(32'(locked_out));
    push_exp("unlock_digit0", 32'(SEG_F));
    wait_digit(0);
    observe(32'(seg_n));
    push_exp("unlock_digit1", 32'(SEG_0));
    wait_digit(1);
    observe(32'(seg_n));
    push_exp("unlock_digit2", 32'(SEG_A));
    wait_digit(2);
    observe(32'(seg_n));
    push_exp("unlock_digit3", 32'(SEG_3));
    wait_digit(3);
    observe(32'(seg_n));
    pulse_err(1);
    pulse_err(1);
    push_exp("unlocked_ignores_err_unlocked", 1);
    push_exp("unlocked_ignores_err_fail_cnt", 0);
    push_exp("unlocked_ignores_err_locked_out", 0);
    observe(32'(unlocked));
    observe(32'(fail_cnt));
    observe(32'(locked_out));

    // scan order in UNLOCKED
    found = 1'b0;
    prev  = an_n;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (an_n == 4'b1110 && prev == 4'b0111) begin
        found = 1'b1;
        break;
      end
      prev = an_n;
    end
    if (!found) chk("scan_start_timeout", 32'(an_n), 32'(4'b1110));
    for (int i = 0; i < 16; i++) push_exp("scan_an", 32'(pat[(i / 2) % 4]));
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      observe(32'(an_n));
    end

    // simultaneous ok/err with two failures: ok wins
    do_reset();
    pulse_err(1);
    pulse_err(1);
    push_exp("tie_pre_fail_cnt", 2);
    observe(32'(fail_cnt));
    ok_in  = 1'b1;
    err_in = 1'b1;
    push_exp("tie_unlocked", 1);
    push_exp("tie_locked_out", 0);
    push_exp("tie_fail_cnt", 0);
    tick();
    observe(32'(unlocked));
    observe(32'(locked_out));
    observe(32'(fail_cnt));
    ok_in  = 1'b0;
    err_in = 1'b0;
    push_exp("tie_stays_unlocked", 1);
    repeat (3) tick();
    observe(32'(unlocked));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
